bit_unpack_buffer: RTL and testbench
====================================

BIT_UNPACK_BUFFER -- requirements
Module: bit_unpack_buffer

Interface
REQ-001 SHALL have parameter BUF_SIZE, default 512, meaning the storage capacity in bits.
REQ-002 SHALL have parameter WORD_SIZE, default 128, meaning the input word width in bits.
REQ-003 SHALL have parameter MAX_OUT, default 256, meaning the maximum extract size in bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 SHALL have port i_word, input, 128 bits: the packed input word, with the oldest bit at bit 127.
REQ-007 SHALL have port i_word_valid, input, 1 bit: the request to append i_word.
REQ-008 SHALL have port o_in_ready, output, 1 bit: high when a word can be accepted.
REQ-009 SHALL have port i_req_size, input, 9 bits: the number of bits to extract, legal range 1..256.
REQ-010 SHALL have port i_req_en, input, 1 bit: the extract request.
REQ-011 SHALL have port o_data, output, 256 bits: the extracted bits, MSB-aligned, with unused low bits zero.
REQ-012 SHALL have port o_valid, output, 1 bit: a one-cycle pulse marking o_data as new.
REQ-013 SHALL have port o_err, output, 1 bit: a one-cycle pulse marking a rejected extract request.
REQ-014 SHALL have port i_flush, input, 1 bit: discards all buffered bits.
REQ-015 SHALL have port o_count, output, 10 bits: the number of valid bits held, range 0..512.
REQ-016 SHALL have ports o_full and o_empty, outputs, 1 bit each: full is count==512; empty is count==0.

Function
REQ-017 SHALL hold the valid bits MSB-aligned in the buffer, occupying buf[511 -: count], with the oldest bit at buf[511].
REQ-018 SHALL drive o_in_ready = (count <= BUF_SIZE-WORD_SIZE) combinationally from the registered count.
REQ-019 SHALL accept a word write when i_word_valid && o_in_ready.
REQ-020 SHALL accept an extract when i_req_en && 1<=i_req_size<=256 && i_req_size<=count, where count is the pre-cycle value (no same-cycle bypass of incoming words).
REQ-021 SHALL, on an accepted extract, register o_data = buf[511 -: 256] with bits below position 256-i_req_size forced to 0, and pulse o_valid the next cycle (1-cycle latency).
REQ-022 SHALL, on an accepted extract, shift buf left by i_req_size and reduce count by i_req_size.
REQ-023 SHALL, on an accepted write, place i_word at buf[511-c' -: 128], where c' is the count after any same-cycle extract, and increase count by 128.
REQ-024 SHALL apply a same-cycle extract and write both, with the extract first: count_next = count - size + 128.
REQ-025 SHALL reject an extract with i_req_size==0, i_req_size>256, or i_req_size>count: pulse o_err next cycle, hold o_data, leave o_valid low, and leave buf/count unchanged.
REQ-026 SHALL hold o_data between accepted extracts and clear o_valid/o_err in every cycle without a new event.
REQ-027 SHALL, when i_flush is high, set count to 0 and buf to 0 and ignore any same-cycle write/extract; o_valid and o_err stay low that cycle.
REQ-028 SHALL keep bits below the valid region at zero at all times, so that appends may use OR.
REQ-029 SHALL compute count arithmetic in at least 10 bits, with no wrap; count never exceeds 512.
REQ-030 SHALL derive o_full/o_empty/o_count combinationally from the registered count.

Reset
REQ-031 SHALL, while rst is high at a clock edge, clear buf, count, o_data, o_valid and o_err, giving o_empty=1, o_full=0, o_in_ready=1, o_count=0.
REQ-032 SHALL let rst take priority over i_flush, writes and extracts; a mid-operation reset discards all data and any pending o_valid.
REQ-033 SHALL begin normal operation in the first cycle after rst is released.

Verification
REQ-034 Bench SHALL cover: reset, then write word 0xFFFF...F (all ones), extract size 4 -> next cycle o_valid=1, o_data[255:252]=4'hF, o_data[251:0]=0, o_count=124.
REQ-035 Bench SHALL cover: four writes with no extracts -> o_count=512, o_full=1, o_in_ready=0; a fifth i_word_valid is ignored and o_count stays 512.
REQ-036 Bench SHALL cover: count=128, extract size 200 -> o_err pulse, o_valid=0, o_count=128; extract size 0 -> o_err pulse.
REQ-037 Bench SHALL cover: count=384, simultaneous extract size 256 and a write -> o_valid=1 with the oldest 256 bits, and o_count=256.
REQ-038 Bench SHALL cover: random word stream with random extract sizes 1..256 -> the concatenated extracted bits equal the concatenated input bits, in order.
REQ-039 Bench SHALL cover: i_flush and rst asserted mid-stream -> o_count=0, o_empty=1 the next cycle, and a following write/extract returns only the new data.

Source files
------------

// File: rtl/bit_unpack_buffer.sv
// bit_unpack_buffer: MSB-aligned bit buffer that appends fixed-width words and
// extracts variable-size bit fields, oldest bit first.
module bit_unpack_buffer #(
  parameter int BUF_SIZE  = 512,
  parameter int WORD_SIZE = 128,
  parameter int MAX_OUT   = 256,
  localparam int CW = $clog2(BUF_SIZE + 1),
  localparam int SW = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] i_word,
  input  logic                 i_word_valid,
  output logic                 o_in_ready,
  input  logic [SW-1:0]        i_req_size,
  input  logic                 i_req_en,
  output logic [MAX_OUT-1:0]   o_data,
  output logic                 o_valid,
  output logic                 o_err,
  input  logic                 i_flush,
  output logic [CW-1:0]        o_count,
  output logic                 o_full,
  output logic                 o_empty
);
  logic [BUF_SIZE-1:0] buf_q, buf_d, buf_x, word_ext;
  logic [CW-1:0]       count_q, count_d, cnt_x, sz;
  logic [MAX_OUT-1:0]  data_q, data_d, mask;
  logic                valid_q, valid_d, err_q, err_d, req_ok, wr;
  assign o_in_ready = count_q <= CW'(BUF_SIZE - WORD_SIZE);
  assign o_count    = count_q;
  assign o_full     = count_q == CW'(BUF_SIZE);
  assign o_empty    = count_q == '0;
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  // Extract is applied before the append, so the word lands right after the
  // bits that survive this cycle's extract; zeros below the valid region let
  // the append be a plain OR.
  always_comb begin
    sz       = CW'(i_req_size);
    req_ok   = i_req_en && sz != '0 && sz <= CW'(MAX_OUT) && sz <= count_q;
    wr       = i_word_valid && o_in_ready;
    buf_x    = req_ok ? buf_q << sz : buf_q;
    cnt_x    = req_ok ? count_q - sz : count_q;
    word_ext = {i_word, {(BUF_SIZE - WORD_SIZE){1'b0}}};
    mask     = ~({MAX_OUT{1'b1}} >> i_req_size);
    buf_d    = i_flush ? '0 : wr ? buf_x | (word_ext >> cnt_x) : buf_x;
    count_d  = i_flush ? '0 : wr ? cnt_x + CW'(WORD_SIZE) : cnt_x;
    data_d   = (req_ok && !i_flush) ? buf_q[BUF_SIZE-1 -: MAX_OUT] & mask : data_q;
    valid_d  = !i_flush && req_ok;
    err_d    = !i_flush && i_req_en && !req_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_bit_unpack_buffer.sv
// tb_bit_unpack_buffer: directed and stream checks of bit_unpack_buffer with a
// bit-queue reference for the random stream.
module tb_bit_unpack_buffer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] i_word = '0;
  logic         i_word_valid = 1'b0;
  logic         o_in_ready;
  logic [8:0]   i_req_size = '0;
  logic         i_req_en = 1'b0;
  logic [255:0] o_data;
  logic         o_valid, o_err;
  logic         i_flush = 1'b0;
  logic [9:0]   o_count;
  logic         o_full, o_empty;
  int checks = 0;
  int errors = 0;

  bit_unpack_buffer dut (
    .clk(clk), .rst(rst), .i_word(i_word), .i_word_valid(i_word_valid),
    .o_in_ready(o_in_ready), .i_req_size(i_req_size), .i_req_en(i_req_en),
    .o_data(o_data), .o_valid(o_valid), .o_err(o_err), .i_flush(i_flush),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    i_word_valid = 1'b0;
    i_req_en     = 1'b0;
    i_flush      = 1'b0;
  endtask

  task automatic wr(input logic [127:0] w);
    i_word = w; i_word_valid = 1'b1;
  endtask

  task automatic ex(input int n);
    i_req_size = 9'(n); i_req_en = 1'b1;
  endtask

  logic [127:0] wa, wb, wc, wd;
  logic [255:0] last, exp;
  logic         q[$];
  int           mcnt, sz;
  bit           dw, de;

  initial begin
    wa = 128'h0123456789abcdef_fedcba9876543210;
    wb = 128'hdeadbeefcafef00d_0badc0de12345678;
    wc = 128'h55aa55aa33cc33cc_0f0f0f0ff0f0f0f0;
    wd = 128'h1122334455667788_99aabbccddeeff00;
    step(); step();
    chk("rst_count", 256'(o_count), 256'd0);
    chk("rst_empty", 256'(o_empty), 256'd1);
    chk("rst_full", 256'(o_full), 256'd0);
    chk("rst_ready", 256'(o_in_ready), 256'd1);
    chk("rst_valid", 256'(o_valid), 256'd0);
    chk("rst_err", 256'(o_err), 256'd0);
    chk("rst_data", o_data, 256'd0);
    rst = 1'b0;

    wr('1); step();
    chk("ones_count", 256'(o_count), 256'd128);
    ex(4); step();
    chk("x4_valid", 256'(o_valid), 256'd1);
    chk("x4_data", o_data, {4'hf, 252'd0});
    chk("x4_count", 256'(o_count), 256'd124);
    step();
    chk("x4_pulse", 256'(o_valid), 256'd0);
    chk("x4_hold", o_data, {4'hf, 252'd0});
    i_flush = 1'b1; step();

    wr(wa); step(); wr(wb); step(); wr(wc); step(); wr(wd); step();
    chk("full_count", 256'(o_count), 256'd512);
    chk("full_full", 256'(o_full), 256'd1);
    chk("full_ready", 256'(o_in_ready), 256'd0);
    wr('1); step();
    chk("full_ignore", 256'(o_count), 256'd512);
    ex(256); step();
    chk("full_x256", o_data, {wa, wb});
    chk("full_x256c", 256'(o_count), 256'd256);
    ex(256); step();
    chk("full_x256b", o_data, {wc, wd});
    chk("full_empty", 256'(o_empty), 256'd1);
    last = {wc, wd};

    wr(wa); step();
    ex(200); step();
    chk("rej200_err", 256'(o_err), 256'd1);
    chk("rej200_valid", 256'(o_valid), 256'd0);
    chk("rej200_count", 256'(o_count), 256'd128);
    chk("rej200_hold", o_data, last);
    ex(0); step();
    chk("rej0_err", 256'(o_err), 256'd1);
    chk("rej0_count", 256'(o_count), 256'd128);
    step();
    chk("err_pulse", 256'(o_err), 256'd0);
    ex(128); step();
    chk("x128_data", o_data, {wa, 128'd0});

    wr(wa); step(); wr(wb); step(); wr(wc); step();
    chk("c384", 256'(o_count), 256'd384);
    ex(256); wr(wd); step();
    chk("sim_valid", 256'(o_valid), 256'd1);
    chk("sim_data", o_data, {wa, wb});
    chk("sim_count", 256'(o_count), 256'd256);
    ex(256); step();
    chk("sim_tail", o_data, {wc, wd});

    mcnt = 0;
    for (int it = 0; it < 300; it++) begin
      dw = (mcnt <= 384) && ($urandom_range(0, 2) != 0);
      de = (mcnt > 0) && ($urandom_range(0, 1) != 0);
      sz = de ? $urandom_range(1, (mcnt < 256) ? mcnt : 256) : 0;
      if (de) begin
        ex(sz);
        exp = '0;
        for (int i = 0; i < sz; i++) exp[255-i] = q.pop_front();
        mcnt -= sz;
      end
      if (dw) begin
        wr({$urandom, $urandom, $urandom, $urandom});
        for (int i = 127; i >= 0; i--) q.push_back(i_word[i]);
        mcnt += 128;
      end
      step();
      chk("rnd_count", 256'(o_count), 256'(mcnt));
      chk("rnd_valid", 256'(o_valid), 256'(de));
      if (de) chk("rnd_data", o_data, exp);
    end

    wr(wa); ex(8); i_flush = 1'b1; step();
    chk("flush_count", 256'(o_count), 256'd0);
    chk("flush_empty", 256'(o_empty), 256'd1);
    chk("flush_valid", 256'(o_valid), 256'd0);
    wr(wb); step();
    ex(128); step();
    chk("flush_new", o_data, {wb, 128'd0});
    wr(wc); step();
    ex(8); rst = 1'b1; step();
    rst = 1'b0;
    chk("mrst_count", 256'(o_count), 256'd0);
    chk("mrst_empty", 256'(o_empty), 256'd1);
    chk("mrst_valid", 256'(o_valid), 256'd0);
    chk("mrst_data", o_data, 256'd0);
    wr(wd); step();
    ex(16); step();
    chk("mrst_new", o_data, {16'h1122, 240'd0});
    chk("mrst_newc", 256'(o_count), 256'd112);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
